// File: rtl/lfsr_checker.sv
// lfsr_checker: synchronisation checker for a 13-bit LFSR word stream.
//
// Each received word is compared against the LFSR successor of the previous
// word. The checker hunts for the sequence (SEARCH), confirms it over
// LOCK_CNT consecutive correct successors (SYNC), and then tracks it (LOCKED).
// In LOCKED, a bad word is replaced by the predicted word, so one corrupted
// word does not break tracking. LOSS_CNT consecutive bad words drop the lock.
//
// Parameters:
//   LOCK_CNT  consecutive correct successor words needed to declare lock
//   LOSS_CNT  consecutive mismatches in LOCKED that drop lock
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   reset      synchronous, active-high reset
//   in_valid   in_word is present this cycle
//   in_word    received 13-bit word
//   locked     checker is synchronised to the sequence (registered)
//   err_pulse  one-cycle pulse per mismatch detected while LOCKED (registered)
//   err_count  total mismatches since reset, saturating at 16'hFFFF (registered)
//   zero_seen  one-cycle pulse when an all-zero word arrives in SEARCH or SYNC
module lfsr_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [12:0] in_word,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic        zero_seen
);

  localparam int unsigned DATA_W  = 13;
  localparam int unsigned MATCH_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0]  LOSS_TGT = MISS_W'(LOSS_CNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   prev, prev_nxt;
  logic [MATCH_W-1:0]  match_cnt, match_nxt, match_inc;
  logic [MISS_W-1:0]   miss_cnt, miss_nxt, miss_inc;
  logic [15:0]         cnt_nxt;
  logic                err_nxt;
  logic                zero_nxt;
  logic                locked_nxt;
  logic [DATA_W-1:0]   expect_word;

  // LFSR successor: shift left, feedback taps 12, 3, 2, 0.
  function automatic logic [DATA_W-1:0] succ(input logic [DATA_W-1:0] w);
    return {w[11:0], w[12] ^ w[3] ^ w[2] ^ w[0]};
  endfunction

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_nxt   = state;
    prev_nxt    = prev;
    match_nxt   = match_cnt;
    miss_nxt    = miss_cnt;
    cnt_nxt     = err_count;
    err_nxt     = 1'b0;
    zero_nxt    = 1'b0;
    expect_word = succ(prev);
    match_inc   = match_cnt + MATCH_W'(1);
    miss_inc    = miss_cnt + MISS_W'(1);

    if (in_valid) begin
      case (state)
        SEARCH: begin
          if (in_word == '0) begin
            // All-zero is the LFSR lock-up word; it can never seed a sequence.
            zero_nxt = 1'b1;
          end else begin
            prev_nxt  = in_word;
            match_nxt = '0;
            state_nxt = SYNC;
          end
        end
        SYNC: begin
          if (in_word == '0) begin
            zero_nxt  = 1'b1;
            match_nxt = '0;
            state_nxt = SEARCH;
          end else if (in_word == expect_word) begin
            prev_nxt  = in_word;
            match_nxt = match_inc;
            if (match_inc == LOCK_TGT) begin
              miss_nxt  = '0;
              state_nxt = LOCKED;
            end
          end else begin
            // Wrong successor: restart the confirmation from this word.
            prev_nxt  = in_word;
            match_nxt = '0;
          end
        end
        LOCKED: begin
          if (in_word == expect_word) begin
            prev_nxt = in_word;
            miss_nxt = '0;
          end else begin
            // Flywheel: keep the predicted word, discard the received one.
            prev_nxt = expect_word;
            err_nxt  = 1'b1;
            cnt_nxt  = sat_inc(err_count);
            if (miss_inc == LOSS_TGT) begin
              miss_nxt  = '0;
              state_nxt = SEARCH;
            end else begin
              miss_nxt = miss_inc;
            end
          end
        end
        default: begin
          state_nxt = SEARCH;
        end
      endcase
    end

    locked_nxt = (state_nxt == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      prev      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      zero_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= locked_nxt;
      err_pulse <= err_nxt;
      err_count <= cnt_nxt;
      zero_seen <= zero_nxt;
    end
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 4: consecutive correct successor words needed to declare lock.
REQ-002 The block SHALL have parameter LOSS_CNT, default 3: consecutive mismatches in LOCKED that drop lock.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  in_word is present this cycle.
REQ-006 The block SHALL have port in_word  input  13  received word from the 13-bit LFSR generator.
REQ-007 The block SHALL have port locked  output  1  checker is synchronised to the sequence.
REQ-008 The block SHALL have port err_pulse  output  1  one-cycle pulse per mismatch detected while LOCKED.
REQ-009 The block SHALL have port err_count  output  16  total mismatches since reset, saturating.
REQ-010 The block SHALL have port zero_seen  output  1  one-cycle pulse when an all-zero word is received in SEARCH or SYNC.

Function
REQ-011 Successor function SHALL be next(w) = {w[11:0], w[12]^w[3]^w[2]^w[0]}.
REQ-012 A word SHALL be accepted only on a rising edge with in_valid=1; when in_valid=0, state, counters and outputs SHALL hold, and pulses SHALL deassert.
REQ-013 FSM states SHALL be SEARCH, SYNC and LOCKED; internal registers SHALL be prev[12:0], match_cnt and miss_cnt.
REQ-014 SEARCH, nonzero word: prev<=word, match_cnt<=0, go to SYNC.
REQ-015 SEARCH or SYNC, zero word: zero_seen SHALL pulse next cycle and the FSM SHALL be in SEARCH.
REQ-016 SYNC, word==next(prev): prev<=word, match_cnt++; on reaching LOCK_CNT, go to LOCKED, miss_cnt<=0.
REQ-017 SYNC, nonzero word!=next(prev): prev<=word (reseed), match_cnt<=0, stay in SYNC.
REQ-018 LOCKED, word==next(prev): prev<=word, miss_cnt<=0.
REQ-019 LOCKED, word!=next(prev): prev<=next(prev) (flywheel, received word discarded), miss_cnt++, err_pulse=1 for one cycle, err_count++.
REQ-020 LOCKED, miss_cnt reaching LOSS_CNT: go to SEARCH and clear miss_cnt; the error on that word SHALL still be counted and pulsed.
REQ-021 Zero words in LOCKED SHALL be treated as ordinary mismatches and SHALL NOT pulse zero_seen.
REQ-022 All outputs SHALL be registered.
REQ-023 locked SHALL be 1 exactly while the FSM is in LOCKED, i.e. from the cycle after the locking word is accepted.
REQ-024 err_pulse and zero_seen SHALL assert in the cycle after the offending word is accepted.
REQ-025 err_count SHALL saturate at 16'hFFFF without wrapping, SHALL be cleared only by reset, and SHALL hold across lock loss.
REQ-026 Back-to-back mismatches SHALL produce back-to-back err_pulse cycles, one per word.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL set state=SEARCH, prev=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0, zero_seen=0.
REQ-028 Reset SHALL take priority over in_valid in the same cycle, and a reset mid-lock SHALL discard the in-flight word.

Verification
REQ-029 Lock acquisition: reset, then valid words 0x000F,0x001F,0x003F,0x007F,0x00FF -> locked=1 the cycle after 0x00FF, err_count=0.
REQ-030 Flywheel: locked after REQ-029, feed 0x0000 where 0x01FF is expected, then 0x03FF -> err_pulse one cycle, err_count=1, locked stays 1, 0x03FF accepted as match.
REQ-031 Lock loss: locked, feed three consecutive 0x1234 -> three err_pulse cycles, err_count increments by 3, locked=0 after the third; resending 0x000F..0x00FF relocks.
REQ-032 Valid gaps and zero: in SEARCH feed 0x0000 -> zero_seen pulse, stay in SEARCH; lock sequence with in_valid low 2 cycles between words -> same lock result as REQ-029.
REQ-033 Reset mid-lock: assert reset while locked with err_count=2 -> next cycle locked=0, err_count=0, and the word presented with reset is ignored.
REQ-034 Saturation: force mismatches past 65535 (relocking as needed) -> err_count holds at 0xFFFF while err_pulse continues to pulse.
